// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: IR encodings, one-hot phase constants,
// sequencer state encoding and instruction classes.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;

  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_P0   = 5'b00001;
  localparam logic [4:0] PH_P1   = 5'b00010;
  localparam logic [4:0] PH_P2   = 5'b00100;
  localparam logic [4:0] PH_P3   = 5'b01000;
  localparam logic [4:0] PH_P4   = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LW,
    CL_SW,
    CL_BR,
    CL_SYS,
    CL_ILL
  } iclass_e;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the phase sequencer and its user.
interface phase_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run;
  logic [5:0]       op;
  logic [5:0]       irfunc;
  logic             mem_ready;
  logic [4:0]       p;
  logic             instr_done;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, op, irfunc, mem_ready,
    input  p, instr_done, halted, illegal, cycle_cnt, instr_cnt
  );

  modport slave (
    input  run, op, irfunc, mem_ready,
    output p, instr_done, halted, illegal, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/instr_classifier.sv
// Combinational decode of {op, irfunc} into the sequencing class.
module instr_classifier
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] irfunc,
  output iclass_e    iclass
);

  always_comb begin
    iclass = CL_ILL;
    case (op)
      OP_RTYPE: begin
        case (irfunc)
          FN_ADD, FN_SLT, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_JR, FN_JALR:  iclass = CL_ALU;
          FN_SYSCALL:      iclass = CL_SYS;
          default:         iclass = CL_ILL;
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_J, OP_JAL:        iclass = CL_ALU;
      OP_LW:               iclass = CL_LW;
      OP_SW:               iclass = CL_SW;
      OP_BEQ, OP_BNE:      iclass = CL_BR;
      default:             iclass = CL_ILL;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multicycle phase generator: walks each instruction through its class path,
// stalls on memory, halts on syscall/illegal, and keeps debug counters.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  phase_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  iclass_e          class_q, class_d;
  iclass_e          dec_class;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;
  logic             in_phase;

  instr_classifier u_classifier (
    .op     (bus.op),
    .irfunc (bus.irfunc),
    .iclass (dec_class)
  );

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_P0;
      ST_P0:   if (bus.mem_ready) state_d = ST_P1;
      ST_P1: begin
        // Class is latched here so later IR changes cannot redirect the path.
        class_d = dec_class;
        case (dec_class)
          CL_SYS: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          CL_ILL: begin
            state_d   = ST_HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
          default: state_d = ST_P2;
        endcase
      end
      ST_P2: begin
        case (class_q)
          CL_BR: begin
            state_d = ST_P0;
            retire  = 1'b1;
          end
          CL_ALU:  state_d = ST_P4;
          default: state_d = ST_P3;
        endcase
      end
      ST_P3: begin
        if (bus.mem_ready) begin
          if (class_q == CL_LW) begin
            state_d = ST_P4;
          end else begin
            state_d = ST_P0;
            retire  = 1'b1;
          end
        end
      end
      ST_P4: begin
        state_d = ST_P0;
        retire  = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    in_phase    = state_q inside {ST_P0, ST_P1, ST_P2, ST_P3, ST_P4};
    cycle_cnt_d = cycle_cnt_q + CNT_W'(in_phase);
    instr_cnt_d = instr_cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      class_q     <= CL_ALU;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    bus.p = PH_NONE;
    case (state_q)
      ST_P0:   bus.p = PH_P0;
      ST_P1:   bus.p = PH_P1;
      ST_P2:   bus.p = PH_P2;
      ST_P3:   bus.p = PH_P3;
      ST_P4:   bus.p = PH_P4;
      default: bus.p = PH_NONE;
    endcase
  end

  assign bus.instr_done = retire;
  assign bus.halted     = halted_q;
  assign bus.illegal    = illegal_q;
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.instr_cnt  = instr_cnt_q;

  a_phase_onehot: assert property (@(posedge clk) disable iff (!reset)
    (state_q inside {ST_P0, ST_P1, ST_P2, ST_P3, ST_P4}) |-> $onehot(bus.p));

  a_phase_idle: assert property (@(posedge clk) disable iff (!reset)
    (state_q inside {ST_IDLE, ST_HALT}) |-> (bus.p == PH_NONE));

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multicycle timing generator that drives the one-hot phase vector p[4:0] consumed by the control unit.
- Walks each instruction through a class-dependent phase path: fetch, decode, execute, memory, writeback.
- Stalls on memory wait and halts on syscall or illegal opcodes.
- Keeps cycle and retired-instruction counters for the debug bus.

Parameters:
CNT_W, 32, width of cycle_cnt and instr_cnt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  start request; sampled only in IDLE
op  in  6  IR[31:26]; valid from P1 onward
irfunc  in  6  IR[5:0]; valid from P1 onward
mem_ready  in  1  memory access completes this cycle; used in P0 and P3
p  out  5  one-hot phase; p[k]=1 in phase Pk, all-zero in IDLE/HALT
instr_done  out  1  high in the final phase cycle of an instruction, on the cycle it advances
halted  out  1  sticky; set on syscall or illegal opcode
illegal  out  1  sticky; set on illegal opcode only
cycle_cnt  out  CNT_W  cycles spent in P0..P4
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (reset=0, async): state=IDLE, p=0, instr_done=0, halted=0, illegal=0, both counters=0. Reset overrides every other event.
- States: IDLE, P0, P1, P2, P3, P4, HALT. State is registered; p decodes directly from state with no extra latency.
- IDLE: run=1 → P0; otherwise stay.
- P0 (fetch): mem_ready=1 → P1; otherwise hold P0.
- P1 (decode): classify {op, irfunc} and register the class. Class is used through P4 and ignores later IR changes.
  - ALU class: add/slt/and/or/xor/nor (op=000000, funct 100000/101010/100100/100101/100110/100111), addiu/andi/ori/xori (001001/001100/001101/001110), jr (func 001000), jalr (func 001001), j (000010), jal (000011).
  - LW: op 100011.
  - SW: op 101011.
  - BR: beq 000100, bne 000101.
  - SYS: op 000000 with func 001100.
  - ILL: anything else.
  - Transitions out of P1: SYS → HALT with halted=1. ILL → HALT with halted=1 and illegal=1. All other classes → P2.
- P2: BR → P0 (retire). ALU → P4. LW and SW → P3.
- P3: hold while mem_ready=0. When mem_ready=1: LW → P4; SW → P0 (retire).
- P4: → P0 (retire), always a single cycle.
- Retire: instr_done=1 for exactly that cycle and instr_cnt increments.
  - Phase counts with no stalls: BR 3, ALU 4, SW 4, LW 5.
  - SYS and ILL do not retire.
- HALT: p=0. Exits only via reset; run is ignored.
- cycle_cnt increments every cycle the state is P0..P4, including stall cycles. Both counters wrap modulo 2^CNT_W silently.
- run is ignored outside IDLE. mem_ready is ignored outside P0 and P3.
- Reset asserted mid-instruction (e.g. in P3) aborts it: no retire, no count.
- Exactly one p bit is high in P0..P4, verified by assertion. p=0 in IDLE and HALT.

Decomposition:
- Shared package (cpu_pkg): opcode/funct localparams, PH_P0..PH_P4 one-hot constants, state encoding, instruction-class enum {CL_ALU, CL_LW, CL_SW, CL_BR, CL_SYS, CL_ILL}.
- Sub-module instr_classifier: combinational {op, irfunc} → class. Reusable by the control unit later.

Test Plan:
- Reset then idle: reset=0 at any point → p=00000, halted=0, illegal=0, counters=0. Release with run=0 → p stays 00000.
- add: run=1, mem_ready=1, op=000000, irfunc=100000 → p sequence 00001, 00010, 00100, 10000, 00001. instr_done high in the 10000 cycle. instr_cnt=1, cycle_cnt=4.
- lw with stall: op=100011, mem_ready=0 for 2 cycles in P3 → p holds 01000 for 3 cycles then 10000. instr_cnt=1, cycle_cnt=7.
- beq then sw back-to-back: beq path 00001, 00010, 00100 retires in 3 cycles. sw path 00001, 00010, 00100, 01000, 00001. instr_cnt=2 after 7 cycles.
- syscall then illegal: op=000000/func=001100 → after P1, p=00000, halted=1, illegal=0, instr_cnt unchanged, run ignored. After reset, op=111111 → halted=1, illegal=1.
- Reset mid-P3 of sw → next cycle IDLE, p=00000, instr_cnt=0. run=1 restarts at P0.
